ex_issue_ctrl: RTL and testbench

//  Sequences the execute stage: buffers decoded instructions, blocks issue on RAW hazards
//  (register scoreboard), drives the execute stage's pipeline-ready/operand handshake and

---
 rtl/rapid_pkg.sv | 45 ++++
 rtl/ex_issue_ctrl_queue.sv | 75 +++++++
 rtl/ex_issue_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_ex_issue_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rapid_pkg.sv
// Shared types for the execute-issue slice.
//   ctrl_state_t : issue sequencer states
//   control_s    : decoded control bundle carried from decode to execute
//   iq_entry_s   : one buffered instruction in the issue queue
package rapid_pkg;

  localparam int XLEN           = 32;
  localparam int REG_AW         = 5;
  localparam int EX_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    CTRL_IDLE    = 2'd0,
    CTRL_ISSUE   = 2'd1,
    CTRL_WAIT_EX = 2'd2,
    CTRL_FLUSH   = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
  } control_s;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    control_s          control;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [REG_AW-1:0] rd_addr;
    logic              rd_we;
  } iq_entry_s;

  // Idle control word: ADD with every side effect disabled.
  function automatic control_s control_s_default();
    control_s c;
    c = '0;
    return c;
  endfunction

endpackage

// File: rtl/ex_issue_ctrl_queue.sv
// Issue queue: IQ_DEPTH-entry FIFO of iq_entry_s with wrap-around pointers.
//   clk_i, rst_i     : clock, async active-high reset (pointers/count only)
//   enq_i/enq_data_i : push request and entry (ignored when full)
//   deq_i            : pop head (ignored when empty)
//   clear_i          : synchronous drop of all entries, wins over enq/deq
//   head_o           : oldest entry, valid when !empty_o
//   full_o, empty_o  : occupancy flags
module ex_issue_queue
  import rapid_pkg::*;
#(
  parameter int IQ_DEPTH = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      enq_i,
  input  iq_entry_s enq_data_i,
  input  logic      deq_i,
  input  logic      clear_i,
  output iq_entry_s head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PW = $clog2(IQ_DEPTH);

  iq_entry_s        mem_q [IQ_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             enq_ok, deq_ok;

  assign full_o  = (count_q == (PW+1)'(IQ_DEPTH));
  assign empty_o = (count_q == '0);
  assign enq_ok  = enq_i && !full_o;
  assign deq_ok  = deq_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (deq_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({enq_ok, deq_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk_i) begin
    if (enq_ok && !clear_i) mem_q[wr_ptr_q] <= enq_data_i;
  end

endmodule

// File: rtl/ex_issue_ctrl.sv
// Execute-stage issue controller.
// Buffers decoded instructions, holds the queue head while either source is
// marked busy in the register scoreboard, issues one instruction at a time to
// execute (pulse + registered operands), waits for execute done, and turns a
// requested PC load into a one-cycle front-end redirect that also drops all
// younger queued instructions.
//   i_id_*            : decode enqueue handshake and instruction fields
//   o_rf_rs*_addr     : regfile read addresses (queue head), data back same cycle
//   o_ex_*            : issue pulse and operands/control held until next issue
//   i_ex_done/pc_load : execute completion and redirect request
//   i_wb_*            : writeback retire, clears the scoreboard bit
//   o_redirect_*      : redirect pulse and target to fetch
//   o_busy_mask, o_state, o_error : status (error = sticky execute timeout)
module ex_issue_ctrl
  import rapid_pkg::*;
#(
  parameter int IQ_DEPTH   = 2,
  parameter int EX_TIMEOUT = EX_TIMEOUT_DEF,
  parameter int NREG       = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_id_valid,
  output logic              o_id_ready,
  input  logic [XLEN-1:0]   i_id_pc,
  input  control_s          i_id_control,
  input  logic [XLEN-1:0]   i_id_imm,
  input  logic [REG_AW-1:0] i_id_rs1_addr,
  input  logic [REG_AW-1:0] i_id_rs2_addr,
  input  logic [REG_AW-1:0] i_id_rd_addr,
  input  logic              i_id_rd_we,
  output logic [REG_AW-1:0] o_rf_rs1_addr,
  output logic [REG_AW-1:0] o_rf_rs2_addr,
  input  logic [XLEN-1:0]   i_rf_rs1_data,
  input  logic [XLEN-1:0]   i_rf_rs2_data,
  output logic              o_ex_pipeline_ready,
  output logic [XLEN-1:0]   o_ex_pc,
  output logic [XLEN-1:0]   o_ex_rs1,
  output logic [XLEN-1:0]   o_ex_rs2,
  output logic [XLEN-1:0]   o_ex_imm,
  output control_s          o_ex_control,
  input  logic              i_ex_done,
  input  logic              i_ex_pc_load,
  input  logic [XLEN-1:0]   i_ex_pc_ext,
  input  logic              i_wb_valid,
  input  logic [REG_AW-1:0] i_wb_rd_addr,
  output logic              o_redirect_valid,
  output logic [XLEN-1:0]   o_redirect_pc,
  output logic [NREG-1:0]   o_busy_mask,
  output ctrl_state_t       o_state,
  output logic              o_error
);

  localparam int CW = $clog2(EX_TIMEOUT + 1);

  ctrl_state_t       state_q, state_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   redir_pc_q, redir_pc_d;
  logic [XLEN-1:0]   ex_pc_q, ex_pc_d, ex_rs1_q, ex_rs1_d;
  logic [XLEN-1:0]   ex_rs2_q, ex_rs2_d, ex_imm_q, ex_imm_d;
  control_s          ex_ctrl_q, ex_ctrl_d;

  iq_entry_s enq_entry, head;
  logic      q_full, q_empty, q_enq, q_deq, q_clear;
  logic      hazard, ex_finish;

  assign enq_entry = '{pc: i_id_pc, control: i_id_control, imm: i_id_imm,
                       rs1_addr: i_id_rs1_addr, rs2_addr: i_id_rs2_addr,
                       rd_addr: i_id_rd_addr, rd_we: i_id_rd_we};

  assign q_enq   = i_id_valid && o_id_ready;
  assign q_deq   = (state_q == CTRL_ISSUE);
  assign q_clear = (state_q == CTRL_FLUSH);

  ex_issue_queue #(.IQ_DEPTH(IQ_DEPTH)) u_queue (
    .clk_i      (i_clk),
    .rst_i      (i_reset),
    .enq_i      (q_enq),
    .enq_data_i (enq_entry),
    .deq_i      (q_deq),
    .clear_i    (q_clear),
    .head_o     (head),
    .full_o     (q_full),
    .empty_o    (q_empty)
  );

  assign o_rf_rs1_addr = head.rs1_addr;
  assign o_rf_rs2_addr = head.rs2_addr;

  // Both sources are always checked, even for formats that ignore rs2; x0 is
  // never set busy so it can't stall.
  assign hazard = busy_q[head.rs1_addr] || busy_q[head.rs2_addr];

  // The first WAIT_EX cycle overlaps execute's own EXECUTE->WAIT transition,
  // so a done seen there is stale from the previous instruction.
  assign ex_finish = i_ex_done && (cnt_q != '0);

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= CTRL_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      CTRL_IDLE:    if (!q_empty && !hazard) state_d = CTRL_ISSUE;
      CTRL_ISSUE:   state_d = CTRL_WAIT_EX;
      CTRL_WAIT_EX: if (ex_finish) state_d = i_ex_pc_load ? CTRL_FLUSH : CTRL_IDLE;
      CTRL_FLUSH:   state_d = CTRL_IDLE;
      default:      state_d = CTRL_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    o_ex_pipeline_ready = (state_q == CTRL_ISSUE);
    o_redirect_valid    = (state_q == CTRL_FLUSH);
    o_id_ready          = !q_full && (state_q != CTRL_FLUSH);
  end

  // Datapath, scoreboard and timeout next-state
  always_comb begin
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    redir_pc_d = redir_pc_q;
    ex_pc_d    = ex_pc_q;
    ex_rs1_d   = ex_rs1_q;
    ex_rs2_d   = ex_rs2_q;
    ex_imm_d   = ex_imm_q;
    ex_ctrl_d  = ex_ctrl_q;

    if (state_q == CTRL_ISSUE) begin
      ex_pc_d   = head.pc;
      ex_rs1_d  = i_rf_rs1_data;
      ex_rs2_d  = i_rf_rs2_data;
      ex_imm_d  = head.imm;
      ex_ctrl_d = head.control;
      cnt_d     = '0;
    end

    if (state_q == CTRL_WAIT_EX) begin
      if (ex_finish) begin
        if (i_ex_pc_load) redir_pc_d = i_ex_pc_ext;
      end else if (cnt_q != CW'(EX_TIMEOUT)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (cnt_d == CW'(EX_TIMEOUT)) err_d = 1'b1;

    // Clear first so a same-cycle set of the same register wins.
    if (i_wb_valid) busy_d[i_wb_rd_addr] = 1'b0;
    if (state_q == CTRL_ISSUE && head.rd_we && head.rd_addr != '0)
      busy_d[head.rd_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      busy_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      redir_pc_q <= '0;
      ex_pc_q    <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_imm_q   <= '0;
      ex_ctrl_q  <= control_s_default();
    end else begin
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      redir_pc_q <= redir_pc_d;
      ex_pc_q    <= ex_pc_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
      ex_imm_q   <= ex_imm_d;
      ex_ctrl_q  <= ex_ctrl_d;
    end
  end

  assign o_ex_pc       = ex_pc_q;
  assign o_ex_rs1      = ex_rs1_q;
  assign o_ex_rs2      = ex_rs2_q;
  assign o_ex_imm      = ex_imm_q;
  assign o_ex_control  = ex_ctrl_q;
  assign o_redirect_pc = redir_pc_q;
  assign o_busy_mask   = busy_q;
  assign o_state       = state_q;
  assign o_error       = err_q;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Bench for ex_issue_ctrl: vector table of single instructions plus
// hand-written hazard, flush, fill/wrap, timeout and reset sequences.
// Issued operands are checked against a scoreboard of accepted entries.
module tb_ex_issue_ctrl;
  import rapid_pkg::*;

  localparam int IQ_DEPTH   = 2;
  localparam int EX_TIMEOUT = 16;
  localparam int NREG       = 32;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_id_valid;
  logic              o_id_ready;
  logic [XLEN-1:0]   i_id_pc, i_id_imm;
  control_s          i_id_control;
  logic [REG_AW-1:0] i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr;
  logic              i_id_rd_we;
  logic [REG_AW-1:0] o_rf_rs1_addr, o_rf_rs2_addr;
  logic [XLEN-1:0]   i_rf_rs1_data, i_rf_rs2_data;
  logic              o_ex_pipeline_ready;
  logic [XLEN-1:0]   o_ex_pc, o_ex_rs1, o_ex_rs2, o_ex_imm;
  control_s          o_ex_control;
  logic              i_ex_done, i_ex_pc_load;
  logic [XLEN-1:0]   i_ex_pc_ext;
  logic              i_wb_valid;
  logic [REG_AW-1:0] i_wb_rd_addr;
  logic              o_redirect_valid;
  logic [XLEN-1:0]   o_redirect_pc;
  logic [NREG-1:0]   o_busy_mask;
  ctrl_state_t       o_state;
  logic              o_error;

  logic done_man, auto_done;
  assign i_ex_done = done_man | (auto_done & (o_state == CTRL_WAIT_EX));

  ex_issue_ctrl #(.IQ_DEPTH(IQ_DEPTH), .EX_TIMEOUT(EX_TIMEOUT), .NREG(NREG)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_id_valid(i_id_valid), .o_id_ready(o_id_ready),
    .i_id_pc(i_id_pc), .i_id_control(i_id_control), .i_id_imm(i_id_imm),
    .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
    .i_id_rd_addr(i_id_rd_addr), .i_id_rd_we(i_id_rd_we),
    .o_rf_rs1_addr(o_rf_rs1_addr), .o_rf_rs2_addr(o_rf_rs2_addr),
    .i_rf_rs1_data(i_rf_rs1_data), .i_rf_rs2_data(i_rf_rs2_data),
    .o_ex_pipeline_ready(o_ex_pipeline_ready),
    .o_ex_pc(o_ex_pc), .o_ex_rs1(o_ex_rs1), .o_ex_rs2(o_ex_rs2), .o_ex_imm(o_ex_imm),
    .o_ex_control(o_ex_control),
    .i_ex_done(i_ex_done), .i_ex_pc_load(i_ex_pc_load), .i_ex_pc_ext(i_ex_pc_ext),
    .i_wb_valid(i_wb_valid), .i_wb_rd_addr(i_wb_rd_addr),
    .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
    .o_busy_mask(o_busy_mask), .o_state(o_state), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  // Regfile stand-in: each register holds a distinct value, x0 reads zero.
  function automatic logic [XLEN-1:0] rfval(input logic [REG_AW-1:0] a);
    return (a == '0) ? 32'h0 : (32'hA500_0000 + 32'(a) * 32'h111);
  endfunction
  assign i_rf_rs1_data = rfval(o_rf_rs1_addr);
  assign i_rf_rs2_data = rfval(o_rf_rs2_addr);

  typedef struct {
    logic [31:0] pc, imm, rs1, rs2;
    logic [9:0]  ctrl;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic [31:0] pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        we;
    logic [31:0] exp_busy;
  } vec_t;
  vec_t vt[4];

  int checks = 0, failures = 0, issues = 0;
  bit pend = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] pc, input logic [31:0] imm,
                     input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic we, input bit push);
    int n = 0;
    exp_t e;
    while (!o_id_ready && n < 60) begin tick(); n++; end
    if (!o_id_ready) begin
      chk("enq_ready_timeout", 64'(o_id_ready), 64'd1);
      return;
    end
    i_id_valid    = 1'b1;
    i_id_pc       = pc;
    i_id_imm      = imm;
    i_id_rs1_addr = rs1;
    i_id_rs2_addr = rs2;
    i_id_rd_addr  = rd;
    i_id_rd_we    = we;
    i_id_control  = control_s'(pc[11:2]);
    if (push) begin
      e.pc = pc; e.imm = imm; e.rs1 = rfval(rs1); e.rs2 = rfval(rs2); e.ctrl = pc[11:2];
      sb.push_back(e);
    end
    tick();
    i_id_valid = 1'b0;
  endtask

  task automatic wait_issue();
    int n = 0;
    while (!o_ex_pipeline_ready && n < 60) begin tick(); n++; end
    if (!o_ex_pipeline_ready) chk("issue_timeout", 64'(o_ex_pipeline_ready), 64'd1);
  endtask

  // Called in the ISSUE cycle; done arrives in the second WAIT_EX cycle.
  task automatic complete(input logic pcl, input logic [31:0] tgt);
    tick(); tick();
    done_man = 1'b1; i_ex_pc_load = pcl; i_ex_pc_ext = tgt;
    tick();
    done_man = 1'b0; i_ex_pc_load = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r);
    i_wb_valid = 1'b1; i_wb_rd_addr = r;
    tick();
    i_wb_valid = 1'b0;
  endtask

  task automatic run_hazard(input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] r, input logic [31:0] pc);
    int np = 0;
    enq(pc, 32'h1, 5'd0, 5'd0, r, 1'b1, 1'b1);
    wait_issue();
    complete(1'b0, 32'h0);
    chk("hz_busy_set", 64'(o_busy_mask), 64'(32'(1) << r));
    enq(pc + 32'h4, 32'h2, rs1, rs2, 5'd0, 1'b0, 1'b1);
    repeat (6) begin
      if (o_ex_pipeline_ready) np++;
      tick();
    end
    chk("hz_stall_pulses", 64'(np), 64'd0);
    wb(r);
    chk("hz_busy_clear", 64'(o_busy_mask), 64'd0);
    chk("hz_no_issue_yet", 64'(o_ex_pipeline_ready), 64'd0);
    tick();
    chk("hz_issue_after_clear", 64'(o_ex_pipeline_ready), 64'd1);
    complete(1'b0, 32'h0);
  endtask

  // Operands appear on o_ex_* the cycle after the issue pulse.
  always @(negedge i_clk) begin
    if (pend) begin
      issues++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue pc=0x%0h expected=none", o_ex_pc);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_pc",   64'(o_ex_pc),  64'(mon_e.pc));
        chk("sb_imm",  64'(o_ex_imm), 64'(mon_e.imm));
        chk("sb_rs1",  64'(o_ex_rs1), 64'(mon_e.rs1));
        chk("sb_rs2",  64'(o_ex_rs2), 64'(mon_e.rs2));
        chk("sb_ctrl", 64'(o_ex_control), 64'(mon_e.ctrl));
      end
    end
    pend = o_ex_pipeline_ready;
  end

  initial begin
    int np, n;
    i_reset = 1'b1; i_id_valid = 1'b0; i_id_pc = '0; i_id_imm = '0;
    i_id_control = control_s_default(); i_id_rs1_addr = '0; i_id_rs2_addr = '0;
    i_id_rd_addr = '0; i_id_rd_we = 1'b0; i_ex_pc_load = 1'b0; i_ex_pc_ext = '0;
    i_wb_valid = 1'b0; i_wb_rd_addr = '0; done_man = 1'b0; auto_done = 1'b0;

    vt[0] = '{32'h0000_0010, 32'd5,         5'd0,  5'd0,  5'd1,  1'b1, 32'h0000_0002};
    vt[1] = '{32'h0000_0014, 32'hFFFF_FFFC, 5'd2,  5'd3,  5'd0,  1'b1, 32'h0000_0000};
    vt[2] = '{32'h0000_0018, 32'h0000_07FF, 5'd4,  5'd0,  5'd5,  1'b0, 32'h0000_0000};
    vt[3] = '{32'h0000_001C, 32'h0000_0123, 5'd31, 5'd30, 5'd31, 1'b1, 32'h8000_0000};

    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_state",    64'(o_state), 64'(CTRL_IDLE));
    chk("rst_busy",     64'(o_busy_mask), 64'd0);
    chk("rst_ex_imm",   64'(o_ex_imm), 64'd0);
    chk("rst_ex_ctrl",  64'(o_ex_control), 64'(control_s_default()));
    chk("rst_redirect", 64'(o_redirect_valid), 64'd0);
    chk("rst_error",    64'(o_error), 64'd0);
    i_reset = 1'b0;
    tick();
    chk("rel_id_ready", 64'(o_id_ready), 64'd1);
    chk("rel_no_issue", 64'(o_ex_pipeline_ready), 64'd0);

    for (int i = 0; i < 4; i++) begin
      enq(vt[i].pc, vt[i].imm, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].we, 1'b1);
      wait_issue();
      tick();
      chk("vec_busy_issue", 64'(o_busy_mask), 64'(vt[i].exp_busy));
      tick();
      done_man = 1'b1;
      tick();
      done_man = 1'b0;
      chk("vec_state_idle", 64'(o_state), 64'(CTRL_IDLE));
      if (vt[i].we) wb(vt[i].rd);
      chk("vec_busy_after_wb", 64'(o_busy_mask), 64'd0);
    end

    run_hazard(5'd1, 5'd1, 5'd1, 32'h100);
    run_hazard(5'd0, 5'd7, 5'd7, 32'h200);

    // Writeback of x3 in the same cycle that issue sets busy[3].
    enq(32'h300, 32'h9, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1);
    wait_issue();
    i_wb_valid = 1'b1; i_wb_rd_addr = 5'd3;
    tick();
    i_wb_valid = 1'b0;
    chk("set_wins", 64'(o_busy_mask), 64'h8);
    tick();
    done_man = 1'b1;
    tick();
    done_man = 1'b0;
    wb(5'd3);
    chk("set_wins_clear", 64'(o_busy_mask), 64'd0);

    // Taken branch with two younger entries queued behind it.
    enq(32'h400, 32'h0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
    wait_issue();
    tick();
    enq(32'h404, 32'h11, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    enq(32'h408, 32'h12, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0);
    done_man = 1'b1; i_ex_pc_load = 1'b1; i_ex_pc_ext = 32'h100;
    tick();
    done_man = 1'b0; i_ex_pc_load = 1'b0;
    chk("flush_state",    64'(o_state), 64'(CTRL_FLUSH));
    chk("flush_redirect", 64'(o_redirect_valid), 64'd1);
    chk("flush_pc",       64'(o_redirect_pc), 64'h100);
    chk("flush_id_ready", 64'(o_id_ready), 64'd0);
    tick();
    chk("flush_pulse_end", 64'(o_redirect_valid), 64'd0);
    np = 0;
    repeat (5) begin
      if (o_ex_pipeline_ready) np++;
      tick();
    end
    chk("flush_queue_empty", 64'(np), 64'd0);
    chk("flush_busy", 64'(o_busy_mask), 64'd0);

    // Fill with execute stalled, then drain through pointer wrap.
    enq(32'h500, 32'h50, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1);
    enq(32'h504, 32'h51, 5'd2, 5'd0, 5'd0, 1'b0, 1'b1);
    enq(32'h508, 32'h52, 5'd3, 5'd0, 5'd0, 1'b0, 1'b1);
    chk("full_id_ready", 64'(o_id_ready), 64'd0);
    chk("full_state", 64'(o_state), 64'(CTRL_WAIT_EX));
    auto_done = 1'b1;
    enq(32'h50C, 32'h53, 5'd4, 5'd5, 5'd0, 1'b0, 1'b1);
    enq(32'h510, 32'h54, 5'd6, 5'd7, 5'd0, 1'b0, 1'b1);
    enq(32'h514, 32'h55, 5'd8, 5'd9, 5'd0, 1'b0, 1'b1);
    enq(32'h518, 32'h56, 5'd10, 5'd11, 5'd0, 1'b0, 1'b1);
    n = 0;
    while ((sb.size() != 0 || o_state != CTRL_IDLE) && n < 300) begin tick(); n++; end
    chk("wrap_drained", 64'(sb.size()), 64'd0);
    auto_done = 1'b0;

    // A done present in the first WAIT_EX cycle must not end the wait.
    enq(32'h600, 32'h60, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    wait_issue();
    done_man = 1'b1;
    tick();
    tick();
    chk("done_ignored_first", 64'(o_state), 64'(CTRL_WAIT_EX));
    tick();
    chk("done_second_cycle", 64'(o_state), 64'(CTRL_IDLE));
    done_man = 1'b0;

    // Execute never finishes: error after EX_TIMEOUT cycles in WAIT_EX.
    enq(32'h700, 32'h70, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1);
    wait_issue();
    repeat (EX_TIMEOUT) tick();
    chk("no_early_error", 64'(o_error), 64'd0);
    tick();
    chk("timeout_error", 64'(o_error), 64'd1);
    chk("timeout_state", 64'(o_state), 64'(CTRL_WAIT_EX));
    done_man = 1'b1;
    tick();
    done_man = 1'b0;
    chk("timeout_exit", 64'(o_state), 64'(CTRL_IDLE));
    chk("error_sticky", 64'(o_error), 64'd1);
    chk("timeout_busy9", 64'(o_busy_mask), 64'h200);

    // Asynchronous reset between clock edges.
    #2;
    i_reset = 1'b1;
    #1;
    chk("arst_busy",  64'(o_busy_mask), 64'd0);
    chk("arst_error", 64'(o_error), 64'd0);
    chk("arst_state", 64'(o_state), 64'(CTRL_IDLE));
    chk("arst_ex_pc", 64'(o_ex_pc), 64'd0);
    chk("arst_redir_pc", 64'(o_redirect_pc), 64'd0);
    tick();
    i_reset = 1'b0;
    tick();
    chk("arst_id_ready", 64'(o_id_ready), 64'd1);
    chk("sb_all_issued", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
